// File: rtl/ayatsuki_bus_fabric_pkg.sv
//------------------------------------------------------------------
// ayatsuki_bus_fabric_pkg - shared types and SoC address map. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package ayatsuki_bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_WAIT = 2'd2
  } rd_state_e;

  // Wide enough for up to 8 slaves plus a distinct "no slave" code
  localparam int              SEL_W    = 4;
  localparam logic [SEL_W-1:0] SEL_NONE = 4'hF;
  localparam int              CNT_W    = 8;

  localparam logic [31:0] SOC_MEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] SOC_MEM_MASK  = 32'h0000_F000;
  localparam logic [31:0] SOC_TIM_BASE  = 32'h0000_1000;
  localparam logic [31:0] SOC_TIM_MASK  = 32'h0000_FF00;
  localparam logic [31:0] SOC_UART_BASE = 32'h0000_2000;
  localparam logic [31:0] SOC_UART_MASK = 32'h0000_FF00;

endpackage

`default_nettype wire

// File: rtl/ayatsuki_bus_fabric_bus_addr_decode.sv
//------------------------------------------------------------------
// bus_addr_decode - priority base/mask address decoder. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module bus_addr_decode
  import ayatsuki_bus_fabric_pkg::*;
#(
  parameter int                        N_SLV    = 4,
  parameter int                        ADDR_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  idx_o
);

  // Scan from the top down so the lowest matching index is the last write
  always_comb begin
    hit_o = 1'b0;
    idx_o = SEL_NONE;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((addr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        idx_o = SEL_W'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ayatsuki_bus_fabric.sv
//------------------------------------------------------------------
// ayatsuki_bus_fabric - core-to-N-slave interconnect with wait states. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module ayatsuki_bus_fabric
  import ayatsuki_bus_fabric_pkg::*;
#(
  parameter int                        N_SLV    = 4,
  parameter int                        ADDR_W   = 32,
  parameter int                        DATA_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0,
  parameter int                        TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m_r_en_i,
  input  logic [ADDR_W-1:0]       m_r_addr_i,
  input  logic                    m_w_en_i,
  input  logic [ADDR_W-1:0]       m_w_addr_i,
  input  logic [DATA_W-1:0]       m_w_data_i,
  output logic [DATA_W-1:0]       m_r_data_o,
  output logic                    m_stall_o,
  output logic                    m_err_o,
  output logic [ADDR_W-1:0]       m_err_addr_o,
  output logic [N_SLV-1:0]        s_r_en_o,
  output logic [N_SLV-1:0]        s_w_en_o,
  output logic [ADDR_W-1:0]       s_r_addr_o,
  output logic [ADDR_W-1:0]       s_w_addr_o,
  output logic [DATA_W-1:0]       s_w_data_o,
  input  logic [N_SLV*DATA_W-1:0] s_r_data_i,
  input  logic [N_SLV-1:0]        s_r_ready_i
);

  logic              r_hit, w_hit;
  logic [SEL_W-1:0]  r_idx, w_idx;

  rd_state_e         state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              w_err_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic              sel_ready;
  logic [DATA_W-1:0] sel_data;
  logic              at_limit;
  logic              rd_err;
  logic              stall;
  logic              w_unmapped;

  bus_addr_decode #(
    .N_SLV    (N_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_rd_decode (
    .addr_i (m_r_addr_i),
    .hit_o  (r_hit),
    .idx_o  (r_idx)
  );

  bus_addr_decode #(
    .N_SLV    (N_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_wr_decode (
    .addr_i (m_w_addr_i),
    .hit_o  (w_hit),
    .idx_o  (w_idx)
  );

  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_ready = s_r_ready_i[k];
        sel_data  = s_r_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign at_limit = (cnt_q == CNT_W'(TIMEOUT));

  // Stall drops in the cycle that completes the read, whether by data or by timeout
  always_comb begin
    stall  = 1'b0;
    rd_err = 1'b0;
    case (state_q)
      ST_DATA: begin
        stall  = (sel_q != SEL_NONE) && !sel_ready;
        rd_err = (sel_q == SEL_NONE);
      end
      ST_WAIT: begin
        stall  = !sel_ready && !at_limit;
        rd_err = !sel_ready && at_limit;
      end
      default: begin
        stall  = 1'b0;
        rd_err = 1'b0;
      end
    endcase
  end

  assign w_unmapped = m_w_en_i && !w_hit && !stall;

  always_comb begin
    s_r_en_o = '0;
    s_w_en_o = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (state_q == ST_WAIT) begin
        s_r_en_o[k] = (sel_q == SEL_W'(k));
      end else begin
        s_r_en_o[k] = m_r_en_i && r_hit && !stall && (r_idx == SEL_W'(k));
      end
      s_w_en_o[k] = m_w_en_i && w_hit && !stall && (w_idx == SEL_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_NONE;
      addr_q     <= '0;
      cnt_q      <= '0;
      w_err_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      w_err_q <= w_unmapped;
      // A write error's pulse lands a cycle later, so its address is the newer one
      if (w_unmapped) begin
        err_addr_q <= m_w_addr_i;
      end else if (rd_err) begin
        err_addr_q <= addr_q;
      end

      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (stall) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_W'(1);
          end else if (m_r_en_i) begin
            state_q <= ST_DATA;
            sel_q   <= r_hit ? r_idx : SEL_NONE;
            addr_q  <= m_r_addr_i;
          end else begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
          end
        end
        ST_WAIT: begin
          if (sel_ready || at_limit) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
            cnt_q   <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= SEL_NONE;
        end
      endcase
    end
  end

  assign m_r_data_o   = ((state_q != ST_IDLE) && sel_ready) ? sel_data : '0;
  assign m_stall_o    = stall;
  assign m_err_o      = w_err_q || rd_err;
  assign m_err_addr_o = err_addr_q;
  assign s_r_addr_o   = m_r_addr_i;
  assign s_w_addr_o   = m_w_addr_i;
  assign s_w_data_o   = m_w_data_i;

endmodule

`default_nettype wire

// File: tb/tb_ayatsuki_bus_fabric.sv
//------------------------------------------------------------------
// tb_ayatsuki_bus_fabric - randomized bench against a transaction model. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_ayatsuki_bus_fabric;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam logic [N*AW-1:0] BASE    = {32'h2000, 32'h1000, 32'h0000};
  localparam logic [N*AW-1:0] MASK    = {32'hFF00, 32'hFF00, 32'hF000};
  localparam logic [N*AW-1:0] BASE_OV = {32'h2000, 32'h0000, 32'h0000};
  localparam logic [N*AW-1:0] MASK_OV = {32'hFF00, 32'h0000, 32'hF000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic          m_r_en = 1'b0, m_w_en = 1'b0;
  logic [AW-1:0] m_r_addr = '0, m_w_addr = '0;
  logic [DW-1:0] m_w_data = '0;
  logic [DW-1:0] sd [N];
  logic [N-1:0]  rdy = 3'b011;
  logic [N*DW-1:0] s_r_data;

  logic [DW-1:0] r_data, ov_r_data;
  logic          stall, err, ov_stall, ov_err;
  logic [AW-1:0] err_addr, ov_err_addr;
  logic [N-1:0]  s_r_en, s_w_en, ov_s_r_en, ov_s_w_en;
  logic [AW-1:0] s_r_addr, s_w_addr, ov_s_r_addr, ov_s_w_addr;
  logic [DW-1:0] s_w_data, ov_s_w_data;

  int n_chk = 0;
  int n_err = 0;

  // Address map as the core sees it: index 0 of each table is slave 0
  logic [31:0] map_base [N] = '{32'h0000, 32'h1000, 32'h2000};
  logic [31:0] map_mask [N] = '{32'hF000, 32'hFF00, 32'hFF00};
  logic [31:0] ov_base  [N] = '{32'h0000, 32'h0000, 32'h2000};
  logic [31:0] ov_mask  [N] = '{32'hF000, 32'h0000, 32'hFF00};

  assign s_r_data = {sd[2], sd[1], sd[0]};

  always #5 clk = ~clk;

  ayatsuki_bus_fabric #(
    .N_SLV(N), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_r_en_i(m_r_en), .m_r_addr_i(m_r_addr),
    .m_w_en_i(m_w_en), .m_w_addr_i(m_w_addr), .m_w_data_i(m_w_data),
    .m_r_data_o(r_data), .m_stall_o(stall), .m_err_o(err), .m_err_addr_o(err_addr),
    .s_r_en_o(s_r_en), .s_w_en_o(s_w_en),
    .s_r_addr_o(s_r_addr), .s_w_addr_o(s_w_addr), .s_w_data_o(s_w_data),
    .s_r_data_i(s_r_data), .s_r_ready_i(rdy)
  );

  ayatsuki_bus_fabric #(
    .N_SLV(N), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASE_OV), .SLV_MASK(MASK_OV), .TIMEOUT(TO)
  ) dut_ov (
    .clk(clk), .rst_n(rst_n),
    .m_r_en_i(m_r_en), .m_r_addr_i(m_r_addr),
    .m_w_en_i(m_w_en), .m_w_addr_i(m_w_addr), .m_w_data_i(m_w_data),
    .m_r_data_o(ov_r_data), .m_stall_o(ov_stall), .m_err_o(ov_err), .m_err_addr_o(ov_err_addr),
    .s_r_en_o(ov_s_r_en), .s_w_en_o(ov_s_w_en),
    .s_r_addr_o(ov_s_r_addr), .s_w_addr_o(ov_s_w_addr), .s_w_data_o(ov_s_w_data),
    .s_r_data_i(s_r_data), .s_r_ready_i(rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int ref_slave(input logic [31:0] a, input bit ov);
    for (int k = 0; k < N; k++) begin
      if (ov ? ((a & ov_mask[k]) == ov_base[k]) : ((a & map_mask[k]) == map_base[k])) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int k);
    return (k < 0) ? 32'h0 : (32'h1 << k);
  endfunction

  // One read, issued from idle; d = cycles slave 2 holds ready low
  task automatic do_read(input logic [31:0] a, input int d_in, input logic [31:0] dv);
    int k, kov, d, exp_stall, nst;
    bit exp_err, done;
    logic [31:0] exp_data;
    k   = ref_slave(a, 1'b0);
    kov = ref_slave(a, 1'b1);
    d   = (k == 2) ? d_in : 0;
    for (int i = 0; i < N; i++) sd[i] = $urandom;
    if (k >= 0) sd[k] = dv;
    exp_err   = (k < 0) || (d >= TO);
    exp_stall = (k < 0) ? 0 : ((d < TO) ? d : TO);
    exp_data  = exp_err ? 32'h0 : dv;

    @(posedge clk); #1;
    m_r_en = 1'b1; m_r_addr = a; rdy = 3'b011;
    @(negedge clk);
    check("rd_issue_en", 32'(s_r_en), onehot(k));
    check("rd_issue_ov_en", 32'(ov_s_r_en), onehot(kov));
    check("rd_issue_stall", 32'(stall), 32'h0);

    nst  = 0;
    done = 1'b0;
    for (int c = 1; c <= TO + 2 && !done; c++) begin
      @(posedge clk); #1;
      m_r_en = 1'b0;
      rdy[2] = (c - 1 >= d);
      @(negedge clk);
      if (stall) begin
        nst++;
        if (c >= 2) check("rd_wait_en_held", 32'(s_r_en), onehot(k));
      end else begin
        done = 1'b1;
        check("rd_data", r_data, exp_data);
        check("rd_err", 32'(err), 32'(exp_err));
        check("rd_stall_cycles", nst, exp_stall);
      end
    end
    check("rd_completed", 32'(done), 32'h1);

    @(posedge clk); #1;
    rdy[2] = 1'b0;
    @(negedge clk);
    check("rd_err_one_cycle", 32'(err), 32'h0);
    check("rd_after_stall", 32'(stall), 32'h0);
    if (exp_err) check("rd_err_addr", err_addr, a);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd);
    int k;
    k = ref_slave(a, 1'b0);
    @(posedge clk); #1;
    m_w_en = 1'b1; m_w_addr = a; m_w_data = wd;
    @(negedge clk);
    check("wr_en", 32'(s_w_en), onehot(k));
    check("wr_data_pass", s_w_data, wd);
    check("wr_addr_pass", s_w_addr, a);
    @(posedge clk); #1;
    m_w_en = 1'b0;
    @(negedge clk);
    check("wr_err", 32'(err), (k < 0) ? 32'h1 : 32'h0);
    check("wr_no_en_after", 32'(s_w_en), 32'h0);
    if (k < 0) check("wr_err_addr", err_addr, a);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_err_clear", 32'(err), 32'h0);
  endtask

  task automatic back_to_back();
    @(posedge clk); #1;
    sd[0] = 32'hA5A5A5A5; sd[1] = 32'h12345678; sd[2] = 32'h0; rdy = 3'b011;
    m_r_en = 1'b1; m_r_addr = 32'h0004;
    @(negedge clk);
    check("b2b_en0", 32'(s_r_en), 32'h1);
    check("b2b_stall0", 32'(stall), 32'h0);
    @(posedge clk); #1;
    m_r_addr = 32'h1008;
    @(negedge clk);
    check("b2b_data0", r_data, 32'hA5A5A5A5);
    check("b2b_stall1", 32'(stall), 32'h0);
    check("b2b_en1", 32'(s_r_en), 32'h2);
    @(posedge clk); #1;
    m_r_en = 1'b0;
    @(negedge clk);
    check("b2b_data1", r_data, 32'h12345678);
    check("b2b_stall2", 32'(stall), 32'h0);
    check("b2b_err", 32'(err), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic reset_in_wait();
    @(posedge clk); #1;
    rdy = 3'b011;
    m_r_en = 1'b1; m_r_addr = 32'h2004;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      m_r_en = 1'b0;
      @(negedge clk);
      check("rst_pre_stall", 32'(stall), 32'h1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wait_stall", 32'(stall), 32'h0);
    check("rst_wait_err", 32'(err), 32'h0);
    check("rst_wait_ren", 32'(s_r_en), 32'h0);
    check("rst_wait_wen", 32'(s_w_en), 32'h0);
    check("rst_wait_data", r_data, 32'h0);
    check("rst_wait_err_addr", err_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) sd[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data", r_data, 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_err_addr", err_addr, 32'h0);
    check("reset_ren", 32'(s_r_en), 32'h0);
    check("reset_wen", 32'(s_w_en), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    back_to_back();
    do_read(32'h2000, 2, 32'h0000CAFE);
    do_read(32'h2004, 99, 32'h0000BEEF);
    do_write(32'h1010, 32'h55);
    do_write(32'h8000, 32'h66);
    do_read(32'h0004, 0, 32'h0BADF00D);
    do_read(32'h1008, 0, 32'h01020304);
    do_read(32'h3000, 0, 32'h0);
    do_read(32'h2010, TO - 1, 32'h7777AAAA);
    reset_in_wait();
    do_read(32'h2008, 0, 32'h13572468);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 16'h3FFF));
      if ($urandom_range(0, 2) == 0) do_write(a, $urandom);
      else do_read(a, $urandom_range(0, 6), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ayatsuki_bus_fabric.md
# ayatsuki_bus_fabric

- Parametrised memory-mapped interconnect between the ayatsuki core data port and N peripheral/memory slaves, generalising the SoC's fixed three-way read mux.
- Decodes read and write addresses against per-slave base/mask windows and steers enables.
- Returns read data through a registered slave-select, so slaves have one-cycle read latency.
- Adds per-slave ready-driven wait states, a stall output to the core, a timeout, and bus-error reporting for unmapped or hung accesses.

## Interface
Parameters:
- N_SLV, 4: number of slaves (1..8)
- ADDR_W, 32: address width
- DATA_W, 32: data width
- SLV_BASE, {N_SLV{ADDR_W'h0}}: packed base addresses, slave k at bits [k*ADDR_W +: ADDR_W]
- SLV_MASK, {N_SLV{ADDR_W'h0}}: packed masks; hit_k = ((addr & MASK_k) == BASE_k)
- TIMEOUT, 15: max wait cycles before error (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- m_r_en_i  in  1  core read request
- m_r_addr_i  in  ADDR_W  core read address
- m_w_en_i  in  1  core write request
- m_w_addr_i  in  ADDR_W  core write address
- m_w_data_i  in  DATA_W  core write data
- m_r_data_o  out  DATA_W  read data, valid in the cycle after issue when m_stall_o=0
- m_stall_o  out  1  core must hold all request inputs while high
- m_err_o  out  1  one-cycle bus-error pulse
- m_err_addr_o  out  ADDR_W  address of most recent error (sticky)
- s_r_en_o  out  N_SLV  one-hot slave read enable
- s_w_en_o  out  N_SLV  one-hot slave write enable
- s_r_addr_o  out  ADDR_W  shared read address
- s_w_addr_o  out  ADDR_W  shared write address
- s_w_data_o  out  DATA_W  shared write data
- s_r_data_i  in  N_SLV*DATA_W  packed slave read data
- s_r_ready_i  in  N_SLV  slave read data valid; tie 1 for fixed one-cycle slaves

## Operation
Decode:
- Multiple hits: lowest index wins.
- No hit: the access is unmapped.
- s_*_addr_o and s_w_data_o pass through from the core.
- s_w_en_o[k] = m_w_en_i & hit_k & ~m_stall_o. Writes are posted and complete in the issue cycle.
- Unmapped write: no enable asserted; m_err_o pulses next cycle; m_err_addr_o <= m_w_addr_i.
- s_r_en_o[k] = m_r_en_i & hit_k, also gated by ~m_stall_o except in WAIT.

Read FSM, states IDLE, DATA, WAIT:
- IDLE: on m_r_en_i:
  - Mapped read: latch sel <= k and addr, go to DATA.
  - Unmapped read: go to DATA with sel = NONE.
- DATA:
  - sel = NONE: m_r_data_o = 0, m_err_o = 1.
  - s_r_ready_i[sel] = 1: m_r_data_o = s_r_data_i[sel], m_stall_o = 0.
  - s_r_ready_i[sel] = 0: m_stall_o = 1, go to WAIT, wait counter cnt <= 1.
  - A new m_r_en_i in DATA with stall low is accepted back-to-back, the same as in IDLE.
- WAIT:
  - m_stall_o = 1; s_r_en_o[sel] held asserted; cnt increments.
  - ready: data returned, stall drops, go to IDLE. A new request is accepted only next cycle.
  - cnt == TIMEOUT and not ready: m_r_data_o = 0, m_err_o = 1, m_err_addr_o <= latched addr, go to IDLE.
- Simultaneous read and write in one cycle: both decoded independently. A write to the slave being waited on is blocked by stall.

## Timing
Reset values:
- State IDLE, sel NONE, cnt 0.
- m_r_data_o 0, m_stall_o 0, m_err_o 0, m_err_addr_o 0; all s_*_en_o 0.

Latency and throughput:
- Read latency is 1 cycle with a ready slave, 1+W cycles for W wait cycles (W < TIMEOUT).
- Error response arrives TIMEOUT+1 cycles after issue.
- Reads to ready slaves sustain one per cycle.
- m_stall_o is combinational from state and s_r_ready_i, giving the core same-cycle backpressure.

Reset mid-operation: reset in WAIT returns to IDLE next edge, with no err pulse and stall 0.

cnt is 8 bits and saturates; it never wraps.

## Structure
- Shared package/define file holds: state encodings (IDLE/DATA/WAIT), SEL_NONE constant, default SoC address map (mem, tim, uart base/mask).
- One sub-module, bus_addr_decode: combinational priority decoder returning hit flag and index. It is instantiated twice, for the read and write paths.
- FSM, counter and mux live in the top module.

## Test plan
All tests use N_SLV=3 with this map:

| Slave | Base | Mask | Type |
|---|---|---|---|
| 0 | 0x0000 | 0xF000 | memory, ready=1 |
| 1 | 0x1000 | 0xFF00 | timer, ready=1 |
| 2 | 0x2000 | 0xFF00 | uart, variable ready |

TIMEOUT=4.

1. Back-to-back reads to 0x0004 then 0x1008 (slave data 0xA5A5A5A5, 0x12345678) -> m_r_data_o shows each value one cycle after its issue, with m_stall_o never high.
2. Read 0x2000 with slave 2 ready delayed 2 cycles, data 0xCAFE -> m_stall_o high for 2 cycles, s_r_en_o=3'b100 held, 0xCAFE returned, no error.
3. Read 0x2004 with slave 2 never ready -> stall high for 4 cycles, then m_r_data_o=0, m_err_o pulses, m_err_addr_o=0x2004.
4. Write 0x1010=0x55 -> s_w_en_o=3'b010 in the same cycle. Write to unmapped 0x8000 -> no enable, m_err_o pulses, m_err_addr_o=0x8000.
5. Overlapping windows: set slave 1 mask to 0x0000 and base to 0x0000, read 0x0004 -> slave 0 is selected (priority).
6. Assert rst_n=0 during WAIT -> next edge: state IDLE, stall 0, err 0, all enables 0.
